// File: rtl/vcu_pkg.sv
// rtl/vcu_pkg.sv - shared encodings for the VCU command sequencer
package vcu_pkg;

    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_SETA = 2'b01;
    localparam logic [1:0] OP_FILL = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WR    = 3'd1;
    localparam logic [2:0] ST_FILL  = 3'd2;
    localparam logic [2:0] ST_RREQ  = 3'd3;
    localparam logic [2:0] ST_RWAIT = 3'd4;

    localparam int               FIFO_DEPTH    = 4;
    localparam int               FIFO_AW       = 2;
    localparam logic [FIFO_AW:0] FIFO_FULL_LVL = 3'd4;

    localparam int STAT_BUSY    = 31;
    localparam int STAT_FULL    = 30;
    localparam int STAT_OVF     = 29;
    localparam int STAT_CMD_ERR = 28;
    localparam int STAT_LVL_LSB = 25;

endpackage

// File: rtl/vcu_fifo.sv
// rtl/vcu_fifo.sv - 4x16 pixel data FIFO; pushes when full and pops when empty are ignored
module vcu_fifo
    import vcu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [15:0]        push_data,
    input  logic               pop,
    output logic [15:0]        pop_data,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   level
);

    logic [15:0]        mem_q [FIFO_DEPTH];
    logic [15:0]        mem_d [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic               push_ok, pop_ok;

    assign full     = (level_q == FIFO_FULL_LVL);
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/vcu_cmd_seq.sv
// rtl/vcu_cmd_seq.sv - CPU command sequencer driving video-memory write/fill/read requests
module vcu_cmd_seq
    import vcu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] vcu_reg_control,
    input  logic        vcu_reg_control_we,
    input  logic [31:0] vcu_reg_wdata,
    input  logic        vcu_reg_wdata_we,
    output logic [31:0] vcu_reg_rdata,
    output logic [15:0] vmem_addr,
    output logic [15:0] vmem_wdata,
    output logic        vmem_we,
    output logic        vmem_re,
    input  logic        vmem_ready,
    input  logic [15:0] vmem_rdata
);

    logic [2:0]         state_q, state_d;
    logic [15:0]        addr_q, addr_d;
    logic [7:0]         stride_q, stride_d;
    logic [11:0]        count_q, count_d;
    logic [15:0]        fill_val_q, fill_val_d;
    logic [15:0]        rdbuf_q, rdbuf_d;
    logic               ovf_q, ovf_d;
    logic               cmd_err_q, cmd_err_d;

    logic               busy, accept, fifo_pop;
    logic               fifo_full, fifo_empty;
    logic [FIFO_AW:0]   fifo_level;
    logic [15:0]        fifo_rdata;
    logic [15:0]        addr_next;
    logic [1:0]         op;
    logic               unused_bits;

    vcu_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vcu_reg_wdata_we),
        .push_data (vcu_reg_wdata[15:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // busy is taken from registered state, so a same-cycle push never blocks a command
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign vmem_we    = (state_q == ST_WR) || (state_q == ST_FILL);
    assign vmem_re    = (state_q == ST_RREQ);
    assign vmem_addr  = addr_q;
    assign vmem_wdata = (state_q == ST_FILL) ? fill_val_q : fifo_rdata;
    assign accept     = (vmem_we || vmem_re) && vmem_ready;
    assign fifo_pop   = (state_q == ST_WR) && accept;
    assign addr_next  = addr_q + {8'd0, stride_q};
    assign op         = vcu_reg_control[31:30];
    assign unused_bits = ^{vcu_reg_wdata[31:16], vcu_reg_control[29:28]};

    assign vcu_reg_rdata = {busy, fifo_full, ovf_q, cmd_err_q, fifo_level, 9'd0, rdbuf_q};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        stride_d   = stride_q;
        count_d    = count_q;
        fill_val_d = fill_val_q;
        rdbuf_d    = rdbuf_q;
        ovf_d      = ovf_q;
        cmd_err_d  = cmd_err_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_WR;
            end
            ST_WR: begin
                if (accept) begin
                    addr_d = addr_next;
                    if (fifo_level == 3'd1 && !vcu_reg_wdata_we) state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (accept) begin
                    addr_d  = addr_next;
                    count_d = count_q - 12'd1;
                    if (count_q == 12'd1) state_d = ST_IDLE;
                end
            end
            ST_RREQ: begin
                if (accept) begin
                    addr_d  = addr_next;
                    state_d = ST_RWAIT;
                end
            end
            ST_RWAIT: begin
                rdbuf_d = vmem_rdata;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Commands other than CLR only start from a quiet IDLE, so they never collide with the FSM above
        if (vcu_reg_control_we) begin
            if (op == OP_CLR) begin
                ovf_d     = 1'b0;
                cmd_err_d = 1'b0;
            end else if (busy) begin
                cmd_err_d = 1'b1;
            end else begin
                case (op)
                    OP_SETA: begin
                        addr_d   = vcu_reg_control[15:0];
                        stride_d = vcu_reg_control[23:16];
                    end
                    OP_FILL: begin
                        if (vcu_reg_control[27:16] != 12'd0) begin
                            count_d    = vcu_reg_control[27:16];
                            fill_val_d = vcu_reg_control[15:0];
                            state_d    = ST_FILL;
                        end
                    end
                    default: state_d = ST_RREQ;
                endcase
            end
        end

        if (vcu_reg_wdata_we && fifo_full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= 16'd0;
            stride_q   <= 8'd1;
            count_q    <= 12'd0;
            fill_val_q <= 16'd0;
            rdbuf_q    <= 16'd0;
            ovf_q      <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            stride_q   <= stride_d;
            count_q    <= count_d;
            fill_val_q <= fill_val_d;
            rdbuf_q    <= rdbuf_d;
            ovf_q      <= ovf_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_vcu_cmd_seq.sv
// tb/tb_vcu_cmd_seq.sv - scoreboard bench for the VCU command sequencer
module tb_vcu_cmd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ctrl = '0;
    logic        ctrl_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        wdata_we = 1'b0;
    logic [31:0] rdata;
    logic [15:0] vmem_addr, vmem_wdata;
    logic        vmem_we, vmem_re;
    logic        vmem_ready = 1'b0;
    logic [15:0] vmem_rdata = 16'h0BAD;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct packed {
        logic        is_rd;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_cyc[$];
    exp_t        got;
    logic        prev_we = 1'b0;
    logic        prev_ready = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [15:0] prev_wdata = '0;

    vcu_cmd_seq dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .vcu_reg_control    (ctrl),
        .vcu_reg_control_we (ctrl_we),
        .vcu_reg_wdata      (wdata),
        .vcu_reg_wdata_we   (wdata_we),
        .vcu_reg_rdata      (rdata),
        .vmem_addr          (vmem_addr),
        .vmem_wdata         (vmem_wdata),
        .vmem_we            (vmem_we),
        .vmem_re            (vmem_re),
        .vmem_ready         (vmem_ready),
        .vmem_rdata         (vmem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: every accepted access is popped from the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_we = 1'b0;
        end else begin
            if (vmem_we || vmem_re) begin
                checks++;
                if (vmem_we && vmem_re) begin
                    failures++;
                    $display("FAIL we_re_exclusive we=%0b re=%0b required not both", vmem_we, vmem_re);
                end
            end
            if (prev_we && !prev_ready) begin
                checks++;
                if (!(vmem_we && vmem_addr === prev_addr && vmem_wdata === prev_wdata)) begin
                    failures++;
                    $display("FAIL write_hold we=%0b addr=%h data=%h required we=1 addr=%h data=%h",
                             vmem_we, vmem_addr, vmem_wdata, prev_addr, prev_wdata);
                end
            end
            if ((vmem_we || vmem_re) && vmem_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_access we=%0b re=%0b addr=%h required no access", vmem_we, vmem_re, vmem_addr);
                end else begin
                    got = exp_q.pop_front();
                    if (vmem_re !== got.is_rd || vmem_addr !== got.addr ||
                        (!got.is_rd && vmem_wdata !== got.data)) begin
                        failures++;
                        $display("FAIL access re=%0b addr=%h data=%h required re=%0b addr=%h data=%h",
                                 vmem_re, vmem_addr, vmem_wdata, got.is_rd, got.addr, got.data);
                    end
                end
                if (vmem_we) acc_cyc.push_back(cyc);
            end
            prev_we    = vmem_we;
            prev_ready = vmem_ready;
            prev_addr  = vmem_addr;
            prev_wdata = vmem_wdata;
        end
    end

    function automatic logic [31:0] w_seta(input logic [15:0] a, input logic [7:0] s);
        return {2'b01, 6'b0, s, a};
    endfunction

    function automatic logic [31:0] w_fill(input logic [11:0] c, input logic [15:0] v);
        return {2'b10, 2'b00, c, v};
    endfunction

    localparam logic [31:0] W_READ = 32'hC000_0000;
    localparam logic [31:0] W_CLR  = 32'h0000_0000;

    task automatic drive(input logic cw, input logic [31:0] cword, input logic dw, input logic [15:0] dval);
        @(posedge clk); #1;
        ctrl_we  = cw;
        ctrl     = cword;
        wdata_we = dw;
        wdata    = {16'hDEAD, dval};
    endtask

    task automatic idle_strobes();
        drive(1'b0, 32'h0, 1'b0, 16'h0);
    endtask

    task automatic push_exp(input logic is_rd, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e.is_rd = is_rd;
        e.addr  = a;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input bit toggle, input int budget, input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (rdata[31] == 1'b0 && exp_q.size() == 0) break;
            n++;
            if (n > budget) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout busy=%0b pending=%0d required idle with 0 pending", name, rdata[31], exp_q.size());
                exp_q.delete();
                break;
            end
            if (toggle) begin
                @(posedge clk); #1;
                vmem_ready = ~vmem_ready;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vmem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL reset_status got=%h required=%h", rdata, 32'h0); end
        checks++;
        if (vmem_we !== 1'b0 || vmem_re !== 1'b0) begin
            failures++; $display("FAIL reset_strobes we=%0b re=%0b required 0 0", vmem_we, vmem_re);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL post_reset_status got=%h required=%h", rdata, 32'h0); end
    endtask

    task automatic test_wr_stride();
        vmem_ready = 1'b1;
        drive(1'b1, w_seta(16'h0010, 8'd2), 1'b0, 16'h0);
        push_exp(1'b0, 16'h0010, 16'h000A);
        push_exp(1'b0, 16'h0012, 16'h000B);
        push_exp(1'b0, 16'h0014, 16'h000C);
        acc_cyc.delete();
        drive(1'b0, 32'h0, 1'b1, 16'h000A);
        drive(1'b0, 32'h0, 1'b1, 16'h000B);
        drive(1'b0, 32'h0, 1'b1, 16'h000C);
        idle_strobes();
        wait_idle(1'b0, 50, "wr");
        checks++;
        if (acc_cyc.size() != 3 || acc_cyc[1] - acc_cyc[0] != 1 || acc_cyc[2] - acc_cyc[1] != 1) begin
            failures++; $display("FAIL wr_consecutive writes=%0d required 3 on consecutive cycles", acc_cyc.size());
        end
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL wr_status got=%h required=%h", rdata, 32'h0); end
    endtask

    task automatic test_fill_wrap();
        vmem_ready = 1'b0;
        drive(1'b1, w_seta(16'hFFFE, 8'd1), 1'b0, 16'h0);
        push_exp(1'b0, 16'hFFFE, 16'h1234);
        push_exp(1'b0, 16'hFFFF, 16'h1234);
        push_exp(1'b0, 16'h0000, 16'h1234);
        drive(1'b1, w_fill(12'd3, 16'h1234), 1'b0, 16'h0);
        idle_strobes();
        wait_idle(1'b1, 100, "fill");
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL fill_status got=%h required=%h", rdata, 32'h0); end
    endtask

    task automatic test_overflow();
        vmem_ready = 1'b0;
        drive(1'b1, w_seta(16'h0200, 8'd4), 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) push_exp(1'b0, 16'h0200 + 16'(4 * i), 16'h0101 + 16'(i));
        for (int i = 0; i < 5; i++) drive(1'b0, 32'h0, 1'b1, 16'h0101 + 16'(i));
        idle_strobes();
        @(negedge clk);
        checks++;
        if (rdata !== 32'hE800_0000) begin failures++; $display("FAIL ovf_status got=%h required=%h", rdata, 32'hE800_0000); end
        drive(1'b1, W_CLR, 1'b0, 16'h0);
        idle_strobes();
        @(negedge clk);
        checks++;
        if (rdata !== 32'hC800_0000) begin failures++; $display("FAIL clr_status got=%h required=%h", rdata, 32'hC800_0000); end
        @(posedge clk); #1;
        vmem_ready = 1'b1;
        wait_idle(1'b0, 50, "ovf");
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL ovf_drain_status got=%h required=%h", rdata, 32'h0); end
    endtask

    task automatic test_read();
        vmem_ready = 1'b0;
        vmem_rdata = 16'h0BAD;
        drive(1'b1, w_seta(16'h0300, 8'd1), 1'b0, 16'h0);
        push_exp(1'b1, 16'h0300, 16'h0);
        drive(1'b1, W_READ, 1'b0, 16'h0);
        idle_strobes();
        @(posedge clk); #1;
        vmem_ready = 1'b1;
        @(posedge clk); #1;
        vmem_ready = 1'b0;
        vmem_rdata = 16'hBEEF;
        @(posedge clk); #1;
        vmem_rdata = 16'h0BAD;
        wait_idle(1'b0, 20, "read");
        checks++;
        if (rdata !== 32'h0000_BEEF) begin failures++; $display("FAIL read_status got=%h required=%h", rdata, 32'h0000_BEEF); end
    endtask

    task automatic test_busy_cmd();
        vmem_ready = 1'b0;
        drive(1'b1, w_seta(16'h0400, 8'd1), 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) push_exp(1'b0, 16'h0400 + 16'(i), 16'h5555);
        drive(1'b1, w_fill(12'd4, 16'h5555), 1'b0, 16'h0);
        idle_strobes();
        drive(1'b1, w_seta(16'h9999, 8'd7), 1'b0, 16'h0);
        idle_strobes();
        @(negedge clk);
        checks++;
        if (rdata !== 32'h9000_BEEF) begin failures++; $display("FAIL cmd_err_status got=%h required=%h", rdata, 32'h9000_BEEF); end
        @(posedge clk); #1;
        vmem_ready = 1'b1;
        wait_idle(1'b0, 50, "busy_fill");
        checks++;
        if (rdata !== 32'h1000_BEEF) begin failures++; $display("FAIL cmd_err_sticky got=%h required=%h", rdata, 32'h1000_BEEF); end
        drive(1'b1, W_CLR, 1'b0, 16'h0);
        idle_strobes();
        @(negedge clk);
        checks++;
        if (rdata !== 32'h0000_BEEF) begin failures++; $display("FAIL cmd_err_clr got=%h required=%h", rdata, 32'h0000_BEEF); end
    endtask

    task automatic test_back_to_back();
        vmem_ready = 1'b1;
        drive(1'b1, w_seta(16'h0600, 8'd1), 1'b0, 16'h0);
        push_exp(1'b0, 16'h0600, 16'hAAAA);
        push_exp(1'b0, 16'h0601, 16'hAAAA);
        push_exp(1'b0, 16'h0602, 16'h0042);
        drive(1'b1, w_fill(12'd2, 16'hAAAA), 1'b1, 16'h0042);
        idle_strobes();
        wait_idle(1'b0, 50, "b2b");
        checks++;
        if (rdata !== 32'h0000_BEEF) begin failures++; $display("FAIL b2b_status got=%h required=%h", rdata, 32'h0000_BEEF); end
    endtask

    task automatic test_reset_mid_fill();
        vmem_ready = 1'b1;
        drive(1'b1, w_seta(16'h0500, 8'd1), 1'b0, 16'h0);
        for (int i = 0; i < 10; i++) push_exp(1'b0, 16'h0500 + 16'(i), 16'h7777);
        drive(1'b1, w_fill(12'd10, 16'h7777), 1'b0, 16'h0);
        drive(1'b0, 32'h0, 1'b1, 16'h0011);
        drive(1'b0, 32'h0, 1'b1, 16'h0022);
        idle_strobes();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (vmem_we !== 1'b0) begin failures++; $display("FAIL reset_abort_we got=%0b required=0", vmem_we); end
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL reset_abort_status got=%h required=%h", rdata, 32'h0); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (rdata !== 32'h0) begin failures++; $display("FAIL reset_fifo_discard got=%h required=%h", rdata, 32'h0); end
    endtask

    initial begin
        test_reset();
        test_wr_stride();
        test_fill_wrap();
        test_overflow();
        test_read();
        test_busy_cmd();
        test_back_to_back();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vcu_cmd_seq.md
VCU_CMD_SEQ -- requirements
Module: vcu_cmd_seq

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset: clk  in  1  clock; rst_n  in  1  synchronous active-low reset.
REQ-002 The module SHALL have these CPU-side ports: vcu_reg_control in 32 (command word); vcu_reg_control_we in 1 (1-cycle command strobe); vcu_reg_wdata in 32 (pixel data, bits [15:0] used); vcu_reg_wdata_we in 1 (1-cycle data strobe); vcu_reg_rdata out 32 (status and read data).
REQ-003 The module SHALL have these video-memory ports: vmem_addr out 16; vmem_wdata out 16; vmem_we out 1; vmem_re out 1; vmem_ready in 1 (arbiter grant); vmem_rdata in 16 (valid the cycle after an accepted read).

Function
REQ-004 The module SHALL decode the command op from control[31:30]: 00 CLR clears sticky flags; 01 SETA sets addr=[15:0] and stride=[23:16] (unsigned); 10 FILL writes count=[27:16] words of value [15:0]; 11 READ reads one word at addr.
REQ-005 The module SHALL treat busy as (state != IDLE) or FIFO not empty.
REQ-006 The module SHALL drop a command strobed while busy and set sticky cmd_err; CLR SHALL always execute, even when busy.
REQ-007 A data strobe SHALL push wdata[15:0] into a 4-entry FIFO; a push when the FIFO is full SHALL be dropped and SHALL set sticky ovf.
REQ-008 When both strobes occur in the same cycle, busy SHALL be evaluated before the push, and both SHALL be processed.
REQ-009 The FSM SHALL use states IDLE, WR, FILL, RREQ and RWAIT.
REQ-010 IDLE SHALL move to WR when the FIFO is non-empty; to FILL on a FILL command with count != 0; and to RREQ on a READ command. FILL with count 0 SHALL be a no-op that leaves the FSM in IDLE.
REQ-011 A request SHALL assert vmem_we or vmem_re with addr and data stable until accepted; acceptance SHALL be req & vmem_ready at the clock edge.
REQ-012 WR SHALL pop one FIFO word per accepted write and SHALL stay in WR while the FIFO is non-empty, otherwise return to IDLE.
REQ-013 FILL SHALL decrement its remaining count per accepted write and SHALL return to IDLE after the last write.
REQ-014 RREQ SHALL move to RWAIT on acceptance; RWAIT SHALL capture vmem_rdata into rdbuf and return to IDLE, so a READ completes 1 cycle after the accepted request.
REQ-015 After every accepted write or read, addr SHALL advance by addr + stride mod 2^16 (wrap at 0xFFFF; stride 0 keeps the same address).
REQ-016 vmem_we and vmem_re SHALL never be asserted together, and SHALL be 0 in IDLE and RWAIT.
REQ-017 The status word SHALL be vcu_reg_rdata = {busy, fifo_full, ovf, cmd_err, level[2:0], 9'b0, rdbuf[15:0]}, combinational from registers.
REQ-018 A SETA accepted in IDLE SHALL take effect for the next access.

Reset
REQ-019 Reset SHALL force state=IDLE, FIFO empty (level 0), addr=0, stride=1, count=0, rdbuf=0, ovf=0 and cmd_err=0.
REQ-020 Reset SHALL drive vmem_we=0 and vmem_re=0; vcu_reg_rdata SHALL then equal 0x00000000.
REQ-021 Reset asserted mid-transfer SHALL abort the transfer within the same edge and SHALL discard FIFO contents, with no further vmem strobes.

Structure
REQ-022 A shared package vcu_pkg SHALL hold the op encodings, FSM state encoding, FIFO depth (4) and status bit positions.
REQ-023 The FIFO SHALL be one sub-module, vcu_fifo (4x16, push/pop/full/empty/level); all other logic SHALL stay in the top module.

Verification
REQ-024 SETA addr=0x0010 stride=2, then 3 data writes 0xA, 0xB, 0xC with vmem_ready=1 -> writes to 0x10, 0x12, 0x14 on consecutive cycles, then busy=0.
REQ-025 FILL count=3 value=0x1234 from addr 0xFFFE stride 1, with vmem_ready toggling 1/0 -> writes to 0xFFFE, 0xFFFF, 0x0000, each held until ready.
REQ-026 With vmem_ready=0, 5 data writes -> level=4, fifo_full=1, ovf=1; then CLR -> ovf=0; then ready=1 -> 4 writes in order.
REQ-027 READ with vmem_rdata=0xBEEF and 1-cycle-late ready -> one vmem_re pulse accepted, rdbuf=0xBEEF, status[15:0]=0xBEEF, busy cleared.
REQ-028 SETA issued during a FILL -> command dropped, cmd_err=1, FILL address sequence unchanged.
REQ-029 rst_n=0 in the middle of FILL count=10 -> vmem_we=0 at the next cycle, status=0x00000000.
